// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the single-MAC matrix multiply sequencer.
package matmul_pkg;

    localparam int MM_DATA_WIDTH  = 16;
    localparam int MM_ACCUM_WIDTH = 2 * MM_DATA_WIDTH;
    localparam int MM_MAX_DIM     = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } mm_state_t;

    // Dimension inputs must be able to hold MAX_DIM itself, not just MAX_DIM-1.
    function automatic int mm_dim_w(input int max_dim);
        return $clog2(max_dim + 32'sd1);
    endfunction

    function automatic int mm_addr_w(input int max_dim);
        return $clog2(max_dim * max_dim);
    endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// i/j/k loop counters with multiplier-free A, B and C address generation.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int DIM_W  = mm_dim_w(MM_MAX_DIM),
    parameter int ADDR_W = mm_addr_w(MM_MAX_DIM)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_step_k,
    input  logic              i_step_elem,
    input  logic [DIM_W-1:0]  i_dim_m,
    input  logic [DIM_W-1:0]  i_dim_n,
    input  logic [DIM_W-1:0]  i_dim_k,
    output logic [ADDR_W-1:0] o_a_addr,
    output logic [ADDR_W-1:0] o_b_addr,
    output logic [ADDR_W-1:0] o_c_addr,
    output logic              o_k_first,
    output logic              o_last_k,
    output logic              o_last_elem
);

    logic [DIM_W-1:0]  r_i;
    logic [DIM_W-1:0]  r_j;
    logic [DIM_W-1:0]  r_k;
    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_a_addr;
    logic [ADDR_W-1:0] r_b_addr;
    logic [ADDR_W-1:0] r_c_addr;
    logic              w_last_j;

    assign o_k_first   = (r_k == {DIM_W{1'b0}});
    assign o_last_k    = (r_k == (i_dim_k - DIM_W'(1'b1)));
    assign w_last_j    = (r_j == (i_dim_n - DIM_W'(1'b1)));
    assign o_last_elem = w_last_j && (r_i == (i_dim_m - DIM_W'(1'b1)));

    assign o_a_addr = r_a_addr;
    assign o_b_addr = r_b_addr;
    assign o_c_addr = r_c_addr;

    // Counters and address registers; a_base tracks i*K so each row restart is a copy, not a multiply.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_i      <= {DIM_W{1'b0}};
            r_j      <= {DIM_W{1'b0}};
            r_k      <= {DIM_W{1'b0}};
            r_a_base <= {ADDR_W{1'b0}};
            r_a_addr <= {ADDR_W{1'b0}};
            r_b_addr <= {ADDR_W{1'b0}};
            r_c_addr <= {ADDR_W{1'b0}};
        end else if (i_step_k) begin
            r_k      <= o_last_k ? {DIM_W{1'b0}} : (r_k + DIM_W'(1'b1));
            r_a_addr <= r_a_addr + ADDR_W'(1'b1);
            r_b_addr <= r_b_addr + ADDR_W'(i_dim_n);
        end else if (i_step_elem) begin
            r_c_addr <= r_c_addr + ADDR_W'(1'b1);
            if (w_last_j) begin
                r_j      <= {DIM_W{1'b0}};
                r_i      <= r_i + DIM_W'(1'b1);
                r_a_base <= r_a_base + ADDR_W'(i_dim_k);
                r_a_addr <= r_a_base + ADDR_W'(i_dim_k);
                r_b_addr <= {ADDR_W{1'b0}};
            end else begin
                r_j      <= r_j + DIM_W'(1'b1);
                r_a_addr <= r_a_base;
                r_b_addr <= ADDR_W'(r_j) + ADDR_W'(1'b1);
            end
        end
    end

endmodule

// File: rtl/matmul_mac_ctrl.sv
// Sequencer computing C = A*B on one external signed 2-stage MAC, one element at a time.
// Optional macro MATMUL_MAC_CTRL_PERF_EN adds busy-cycle and overflow-element counters.
module matmul_mac_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = MM_DATA_WIDTH,
    parameter int ACCUM_WIDTH = 2 * DATA_WIDTH,
    parameter int MAX_DIM     = MM_MAX_DIM,
    parameter int DIM_W       = mm_dim_w(MAX_DIM),
    parameter int ADDR_W      = mm_addr_w(MAX_DIM)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [DIM_W-1:0]              i_cfg_m,
    input  logic [DIM_W-1:0]              i_cfg_n,
    input  logic [DIM_W-1:0]              i_cfg_k,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_cfg_err,
    output logic [ADDR_W-1:0]             o_a_addr,
    output logic [ADDR_W-1:0]             o_b_addr,
    output logic                          o_a_rd,
    output logic                          o_b_rd,
    input  logic signed [DATA_WIDTH-1:0]  i_a_rdata,
    input  logic signed [DATA_WIDTH-1:0]  i_b_rdata,
    output logic                          o_mac_clr,
    output logic                          o_mac_running,
    output logic signed [DATA_WIDTH-1:0]  o_mac_in1,
    output logic signed [DATA_WIDTH-1:0]  o_mac_in2,
    input  logic signed [ACCUM_WIDTH-1:0] i_mac_total,
    input  logic                          i_mac_err,
`ifdef MATMUL_MAC_CTRL_PERF_EN
    output logic [31:0]                   o_perf_cycles,
    output logic [2*DIM_W-1:0]            o_perf_ovf_cnt,
`endif
    output logic                          o_c_wr,
    output logic [ADDR_W-1:0]             o_c_addr,
    output logic signed [ACCUM_WIDTH-1:0] o_c_wdata,
    output logic                          o_c_err,
    output logic                          o_ovf_any
);

    mm_state_t         r_state;
    mm_state_t         w_state_nxt;
    logic [DIM_W-1:0]  r_dim_m;
    logic [DIM_W-1:0]  r_dim_n;
    logic [DIM_W-1:0]  r_dim_k;
    logic              r_d_vld;
    logic              r_d_first;
    logic              r_cfg_err;
    logic              r_ovf_any;
    logic              w_cfg_ok;
    logic              w_accept;
    logic              w_reject;
    logic              w_is_issue;
    logic              w_is_flush;
    logic              w_is_write;
    logic [ADDR_W-1:0] w_a_addr;
    logic [ADDR_W-1:0] w_b_addr;
    logic [ADDR_W-1:0] w_c_addr;
    logic              w_k_first;
    logic              w_last_k;
    logic              w_last_elem;

    assign w_cfg_ok = (i_cfg_m != {DIM_W{1'b0}}) && (i_cfg_m <= DIM_W'(MAX_DIM)) &&
                      (i_cfg_n != {DIM_W{1'b0}}) && (i_cfg_n <= DIM_W'(MAX_DIM)) &&
                      (i_cfg_k != {DIM_W{1'b0}}) && (i_cfg_k <= DIM_W'(MAX_DIM));

    assign w_is_issue = (r_state == ST_ISSUE);
    assign w_is_flush = (r_state == ST_FLUSH);
    assign w_is_write = (r_state == ST_WRITE);

    matmul_addr_gen #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_accept),
        .i_step_k    (w_is_issue),
        .i_step_elem (w_is_write),
        .i_dim_m     (r_dim_m),
        .i_dim_n     (r_dim_n),
        .i_dim_k     (r_dim_k),
        .o_a_addr    (w_a_addr),
        .o_b_addr    (w_b_addr),
        .o_c_addr    (w_c_addr),
        .o_k_first   (w_k_first),
        .o_last_k    (w_last_k),
        .o_last_elem (w_last_elem)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus start accept/reject strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && w_cfg_ok) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else if (i_start) begin
                    w_reject    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_last_k) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN: w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (w_last_elem) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch dimensions only on an accepted start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dim_m <= {DIM_W{1'b0}};
            r_dim_n <= {DIM_W{1'b0}};
            r_dim_k <= {DIM_W{1'b0}};
        end else if (w_accept) begin
            r_dim_m <= i_cfg_m;
            r_dim_n <= i_cfg_n;
            r_dim_k <= i_cfg_k;
        end
    end

    // Operand pipeline flags line up with the one-cycle memory read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d_vld   <= 1'b0;
            r_d_first <= 1'b0;
        end else begin
            r_d_vld   <= w_is_issue;
            r_d_first <= w_is_issue && w_k_first;
        end
    end

    // Config-error pulse and job-sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg_err <= 1'b0;
            r_ovf_any <= 1'b0;
        end else begin
            r_cfg_err <= w_reject;
            if (w_accept) begin
                r_ovf_any <= 1'b0;
            end else if (w_is_write && i_mac_err) begin
                r_ovf_any <= 1'b1;
            end
        end
    end

    assign o_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done    = (r_state == ST_DONE);
    assign o_cfg_err = r_cfg_err;
    assign o_ovf_any = r_ovf_any;

    assign o_a_rd   = w_is_issue;
    assign o_b_rd   = w_is_issue;
    assign o_a_addr = w_is_issue ? w_a_addr : {ADDR_W{1'b0}};
    assign o_b_addr = w_is_issue ? w_b_addr : {ADDR_W{1'b0}};

    // clr lands on the first product latch, so the previous element's last product is discarded.
    assign o_mac_clr     = r_d_first;
    assign o_mac_running = r_d_vld || w_is_flush;
    assign o_mac_in1     = r_d_vld ? i_a_rdata : {DATA_WIDTH{1'b0}};
    assign o_mac_in2     = r_d_vld ? i_b_rdata : {DATA_WIDTH{1'b0}};

    assign o_c_wr    = w_is_write;
    assign o_c_addr  = w_is_write ? w_c_addr : {ADDR_W{1'b0}};
    assign o_c_wdata = w_is_write ? i_mac_total : {ACCUM_WIDTH{1'b0}};
    assign o_c_err   = w_is_write && i_mac_err;

`ifdef MATMUL_MAC_CTRL_PERF_EN
    logic [31:0]      r_perf_cycles;
    logic [2*DIM_W-1:0] r_perf_ovf_cnt;

    // Busy-cycle and overflowed-element counters, restarted on each accepted job.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept) begin
            r_perf_cycles  <= 32'd0;
            r_perf_ovf_cnt <= {(2*DIM_W){1'b0}};
        end else begin
            if (o_busy) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (w_is_write && i_mac_err) begin
                r_perf_ovf_cnt <= r_perf_ovf_cnt + (2*DIM_W)'(1'b1);
            end
        end
    end

    assign o_perf_cycles  = r_perf_cycles;
    assign o_perf_ovf_cnt = r_perf_ovf_cnt;
`endif

endmodule

// File: tb/tb_matmul_mac_ctrl.sv
// Directed bench for matmul_mac_ctrl with A/B memory models and a 2-stage signed MAC model.
module tb_matmul_mac_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [4:0]         cfg_m, cfg_n, cfg_k;
    logic               busy, done, cfg_err;
    logic [7:0]         a_addr, b_addr, c_addr;
    logic               a_rd, b_rd;
    logic signed [15:0] a_rdata, b_rdata;
    logic               mac_clr, mac_running;
    logic signed [15:0] mac_in1, mac_in2;
    logic signed [31:0] mac_total;
    logic               mac_err;
    logic               c_wr, c_err, ovf_any;
    logic signed [31:0] c_wdata;

    logic signed [15:0] mem_a [256];
    logic signed [15:0] mem_b [256];
    logic signed [31:0] mac_prod;

    logic [7:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    logic        wr_err  [$];
    int          done_cnt;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    matmul_mac_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_cfg_m       (cfg_m),
        .i_cfg_n       (cfg_n),
        .i_cfg_k       (cfg_k),
        .o_busy        (busy),
        .o_done        (done),
        .o_cfg_err     (cfg_err),
        .o_a_addr      (a_addr),
        .o_b_addr      (b_addr),
        .o_a_rd        (a_rd),
        .o_b_rd        (b_rd),
        .i_a_rdata     (a_rdata),
        .i_b_rdata     (b_rdata),
        .o_mac_clr     (mac_clr),
        .o_mac_running (mac_running),
        .o_mac_in1     (mac_in1),
        .o_mac_in2     (mac_in2),
        .i_mac_total   (mac_total),
        .i_mac_err     (mac_err),
        .o_c_wr        (c_wr),
        .o_c_addr      (c_addr),
        .o_c_wdata     (c_wdata),
        .o_c_err       (c_err),
        .o_ovf_any     (ovf_any)
    );

    always @(posedge clk) begin
        if (a_rd) a_rdata <= mem_a[a_addr];
        if (b_rd) b_rdata <= mem_b[b_addr];
    end

    function automatic logic add_ovf(input logic signed [31:0] x, input logic signed [31:0] y);
        logic signed [31:0] s;
        s = x + y;
        return (x[31] == y[31]) && (s[31] != x[31]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mac_prod  <= 32'sd0;
            mac_total <= 32'sd0;
            mac_err   <= 1'b0;
        end else if (mac_clr) begin
            mac_prod  <= mac_in1 * mac_in2;
            mac_total <= 32'sd0;
            mac_err   <= 1'b0;
        end else if (mac_running) begin
            mac_prod  <= mac_in1 * mac_in2;
            mac_total <= mac_total + mac_prod;
            mac_err   <= mac_err | add_ovf(mac_total, mac_prod);
        end
    end

    always @(negedge clk) begin
        if (!rst && c_wr) begin
            wr_addr.push_back(c_addr);
            wr_data.push_back(c_wdata);
            wr_err.push_back(c_err);
        end
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_err.delete();
        done_cnt = 0;
    endtask

    task automatic run_job(input logic [4:0] m, input logic [4:0] n, input logic [4:0] k,
                           input int poke_cyc, output int done_cyc);
        clear_log();
        cfg_m = m; cfg_n = n; cfg_k = k;
        start = 1'b1;
        step();
        start = 1'b0;
        done_cyc = -1;
        for (int cyc = 1; cyc < 2000; cyc++) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == poke_cyc);
            step();
        end
        start = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_m = 5'd0; cfg_n = 5'd0; cfg_k = 5'd0;
        step();
        step();
        rst = 1'b0;
        step();
        total++;
        if ({busy, done, cfg_err, a_rd, b_rd, mac_clr, mac_running, c_wr, c_err, ovf_any} !== 10'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0", {busy, done, cfg_err, a_rd, b_rd, mac_clr, mac_running, c_wr, c_err, ovf_any});
        end
        total++;
        if ({a_addr, b_addr, c_addr} !== 24'h0) begin
            bad++;
            $display("FAIL reset_addr got=%h want=0", {a_addr, b_addr, c_addr});
        end
        total++;
        if ({mac_in1, mac_in2, c_wdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {mac_in1, mac_in2, c_wdata});
        end
    endtask

    task automatic test_single();
        logic exp_wr, exp_done, exp_busy;
        mem_a[0] = 16'sd3;
        mem_b[0] = -16'sd4;
        clear_log();
        cfg_m = 5'd1; cfg_n = 5'd1; cfg_k = 5'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            exp_wr   = (cyc == 4);
            exp_done = (cyc == 5);
            exp_busy = (cyc >= 1) && (cyc <= 4);
            total++;
            if (c_wr !== exp_wr) begin
                bad++;
                $display("FAIL single_c_wr cyc=%0d got=%b want=%b", cyc, c_wr, exp_wr);
            end
            total++;
            if (done !== exp_done || busy !== exp_busy) begin
                bad++;
                $display("FAIL single_done_busy cyc=%0d got=%b%b want=%b%b", cyc, done, busy, exp_done, exp_busy);
            end
            if (cyc == 1) begin
                total++;
                if (a_rd !== 1'b1 || b_rd !== 1'b1 || a_addr !== 8'd0 || b_addr !== 8'd0) begin
                    bad++;
                    $display("FAIL single_issue got rd=%b%b addr=%0d/%0d want 11 0/0", a_rd, b_rd, a_addr, b_addr);
                end
            end
            if (cyc == 4) begin
                total++;
                if (c_addr !== 8'd0 || c_wdata !== -32'sd12 || c_err !== 1'b0) begin
                    bad++;
                    $display("FAIL single_write got addr=%0d data=%0d err=%b want 0 -12 0", c_addr, c_wdata, c_err);
                end
            end
            step();
        end
    endtask

    task automatic test_matrix_2x2();
        int dc;
        int exp_c[4];
        exp_c = '{32'sd19, 32'sd22, 32'sd43, 32'sd50};
        mem_a[0] = 16'sd1; mem_a[1] = 16'sd2; mem_a[2] = 16'sd3; mem_a[3] = 16'sd4;
        mem_b[0] = 16'sd5; mem_b[1] = 16'sd6; mem_b[2] = 16'sd7; mem_b[3] = 16'sd8;
        run_job(5'd2, 5'd2, 5'd2, 5, dc);
        total++;
        if (dc !== 21) begin
            bad++;
            $display("FAIL mm2_done_cycle got=%0d want=21", dc);
        end
        total++;
        if (wr_addr.size() !== 4 || done_cnt !== 1) begin
            bad++;
            $display("FAIL mm2_counts got writes=%0d dones=%0d want 4 1", wr_addr.size(), done_cnt);
        end else begin
            for (int e = 0; e < 4; e++) begin
                total++;
                if (wr_addr[e] !== 8'(e) || wr_data[e] !== exp_c[e] || wr_err[e] !== 1'b0) begin
                    bad++;
                    $display("FAIL mm2_elem%0d got addr=%0d data=%0d err=%b want %0d %0d 0",
                             e, wr_addr[e], $signed(wr_data[e]), wr_err[e], e, exp_c[e]);
                end
            end
        end
    endtask

    task automatic test_stale_product();
        int dc;
        mem_a[0] = 16'sd7; mem_a[1] = 16'sd0;
        mem_b[0] = 16'sd5; mem_b[1] = 16'sd0;
        run_job(5'd2, 5'd1, 5'd1, -1, dc);
        total++;
        if (dc !== 9 || wr_addr.size() !== 2) begin
            bad++;
            $display("FAIL stale_shape got done=%0d writes=%0d want 9 2", dc, wr_addr.size());
        end else begin
            total++;
            if (wr_data[0] !== 32'd35 || wr_data[1] !== 32'd0 || wr_addr[1] !== 8'd1) begin
                bad++;
                $display("FAIL stale_data got %0d,%0d @%0d want 35,0 @1", wr_data[0], wr_data[1], wr_addr[1]);
            end
        end
    endtask

    task automatic test_overflow();
        int dc;
        mem_a[0] = -16'sd32768; mem_a[1] = -16'sd32768;
        mem_b[0] = -16'sd32768; mem_b[1] = -16'sd32768;
        run_job(5'd1, 5'd1, 5'd2, -1, dc);
        total++;
        if (dc !== 6 || wr_addr.size() !== 1) begin
            bad++;
            $display("FAIL ovf_shape got done=%0d writes=%0d want 6 1", dc, wr_addr.size());
        end else begin
            total++;
            if (wr_err[0] !== 1'b1 || wr_data[0] !== 32'h8000_0000) begin
                bad++;
                $display("FAIL ovf_elem got err=%b data=%h want 1 80000000", wr_err[0], wr_data[0]);
            end
        end
        total++;
        if (ovf_any !== 1'b1) begin
            bad++;
            $display("FAIL ovf_any_set got=%b want=1", ovf_any);
        end
        mem_a[0] = 16'sd3;
        mem_b[0] = -16'sd4;
        run_job(5'd1, 5'd1, 5'd1, -1, dc);
        total++;
        if (ovf_any !== 1'b0 || wr_err.size() !== 1 || wr_err[0] !== 1'b0 || wr_data[0] !== 32'hFFFF_FFF4) begin
            bad++;
            $display("FAIL ovf_any_clear got ovf_any=%b writes=%0d want 0 1 (-12, err 0)", ovf_any, wr_err.size());
        end
    endtask

    task automatic test_cfg_err();
        logic [4:0] bad_m [2];
        logic [4:0] bad_k [2];
        bad_m = '{5'd2, 5'd17};
        bad_k = '{5'd0, 5'd1};
        for (int t = 0; t < 2; t++) begin
            cfg_m = bad_m[t]; cfg_n = 5'd1; cfg_k = bad_k[t];
            start = 1'b1;
            step();
            start = 1'b0;
            total++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || a_rd !== 1'b0) begin
                bad++;
                $display("FAIL cfg_err%0d_pulse got err=%b busy=%b rd=%b want 1 0 0", t, cfg_err, busy, a_rd);
            end
            step();
            total++;
            if (cfg_err !== 1'b0 || busy !== 1'b0 || a_rd !== 1'b0) begin
                bad++;
                $display("FAIL cfg_err%0d_after got err=%b busy=%b rd=%b want 0 0 0", t, cfg_err, busy, a_rd);
            end
        end
    endtask

    task automatic test_max_dim();
        int dc;
        for (int e = 0; e < 16; e++) mem_a[e] = 16'(e + 1);
        mem_b[0] = 16'sd2;
        run_job(5'd16, 5'd1, 5'd1, -1, dc);
        total++;
        if (dc !== 65 || wr_addr.size() !== 16) begin
            bad++;
            $display("FAIL maxdim_shape got done=%0d writes=%0d want 65 16", dc, wr_addr.size());
        end else begin
            for (int e = 0; e < 16; e += 5) begin
                total++;
                if (wr_addr[e] !== 8'(e) || wr_data[e] !== 32'(2 * (e + 1))) begin
                    bad++;
                    $display("FAIL maxdim_elem%0d got addr=%0d data=%0d want %0d %0d", e, wr_addr[e], wr_data[e], e, 2 * (e + 1));
                end
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int dc;
        int exp_c[4];
        exp_c = '{32'sd19, 32'sd22, 32'sd43, 32'sd50};
        mem_a[0] = 16'sd1; mem_a[1] = 16'sd2; mem_a[2] = 16'sd3; mem_a[3] = 16'sd4;
        mem_b[0] = 16'sd5; mem_b[1] = 16'sd6; mem_b[2] = 16'sd7; mem_b[3] = 16'sd8;
        clear_log();
        cfg_m = 5'd2; cfg_n = 5'd2; cfg_k = 5'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc < 6; cyc++) step();
        total++;
        if (a_rd !== 1'b1 || a_addr !== 8'd0 || b_addr !== 8'd1) begin
            bad++;
            $display("FAIL rstmid_issue got rd=%b a=%0d b=%0d want 1 0 1", a_rd, a_addr, b_addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({busy, done, a_rd, mac_clr, mac_running, c_wr, ovf_any} !== 7'b0 ||
            {a_addr, b_addr, c_addr, mac_in1, mac_in2, c_wdata} !== 88'h0) begin
            bad++;
            $display("FAIL rstmid_outputs got ctrl=%b data=%h want 0", {busy, done, a_rd, mac_clr, mac_running, c_wr, ovf_any},
                     {a_addr, b_addr, c_addr, mac_in1, mac_in2, c_wdata});
        end
        for (int cyc = 0; cyc < 30; cyc++) step();
        total++;
        if (done_cnt !== 0 || wr_addr.size() !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_abort got dones=%0d writes=%0d busy=%b want 0 1 0", done_cnt, wr_addr.size(), busy);
        end
        run_job(5'd2, 5'd2, 5'd2, -1, dc);
        total++;
        if (dc !== 21 || wr_addr.size() !== 4) begin
            bad++;
            $display("FAIL rstmid_rerun_shape got done=%0d writes=%0d want 21 4", dc, wr_addr.size());
        end else begin
            for (int e = 0; e < 4; e++) begin
                total++;
                if (wr_addr[e] !== 8'(e) || wr_data[e] !== exp_c[e]) begin
                    bad++;
                    $display("FAIL rstmid_rerun_elem%0d got addr=%0d data=%0d want %0d %0d", e, wr_addr[e], wr_data[e], e, exp_c[e]);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        done_cnt = 0;
        test_reset();
        test_single();
        test_matrix_2x2();
        test_stale_product();
        test_overflow();
        test_cfg_err();
        test_max_dim();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_mac_ctrl.md
Name: matmul_mac_ctrl

Overview:
- Sequencer that computes C = A(MxK) * B(KxN) on a single signed MAC unit, one output element at a time.
- Generates read addresses into the A and B operand memories (synchronous read, 1-cycle latency) and gates the returned operands into the MAC.
- Drives the MAC clr/running controls so they match its 2-stage timing: registered product, then accumulate.
- Writes each finished total, with its overflow flag, to the C memory.

Parameters:
- DATA_WIDTH, 16, operand width; must match the MAC.
- ACCUM_WIDTH, 2*DATA_WIDTH, MAC total width; must match the MAC.
- MAX_DIM, 16, largest legal M, N, K.
- DIM_W, $clog2(MAX_DIM+1), width of the dimension inputs.
- ADDR_W, $clog2(MAX_DIM*MAX_DIM), width of the A, B and C addresses.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- cfg_m, cfg_n, cfg_k  in  DIM_W each  matrix dimensions, sampled when start is accepted.
- busy  out  1  high from the cycle after acceptance until DONE.
- done  out  1  one-cycle pulse when the whole matrix is complete.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- a_addr, b_addr  out  ADDR_W  operand read addresses.
- a_rd, b_rd  out  1  read enables.
- a_rdata, b_rdata  in  DATA_WIDTH  signed; valid the cycle after a_rd/b_rd.
- mac_clr, mac_running  out  1  MAC controls.
- mac_in1, mac_in2  out  DATA_WIDTH  gated operands to the MAC.
- mac_total  in  ACCUM_WIDTH  MAC accumulator.
- mac_err  in  1  MAC sticky overflow flag.
- c_wr  out  1  C write strobe.
- c_addr  out  ADDR_W  C write address.
- c_wdata  out  ACCUM_WIDTH  C write data.
- c_err  out  1  per-element overflow flag, written alongside c_wdata.
- ovf_any  out  1  sticky: any element overflowed during the current job.

Behaviour:
- Reset: state IDLE. All outputs 0, all counters and addresses 0. A reset mid-job aborts the job immediately with no done pulse; the next start works normally.
- States: IDLE, ISSUE, DRAIN, FLUSH, WRITE, DONE.
- IDLE, start=1 with all dims in 1..MAX_DIM:
  - latch the dims; clear i, j, k and ovf_any; go to ISSUE.
- IDLE, start=1 with any dim equal to 0 or greater than MAX_DIM:
  - cfg_err=1 for one cycle; stay in IDLE.
- start while not in IDLE is ignored.
- ISSUE: lasts K cycles, k = 0..K-1.
  - a_rd = b_rd = 1, a_addr = i*K + k, b_addr = k*N + j.
  - Addresses are formed incrementally, with no multipliers: a_addr steps +1 per k, the row base steps +K per i; b_addr steps +N per k.
  - After k = K-1, go to DRAIN.
- Operand pipeline: registered flags d_vld = issue-cycle and d_first = (k==0), each delayed one cycle.
  - mac_running = d_vld | (state==FLUSH).
  - mac_clr = d_first.
  - mac_in1/mac_in2 = a_rdata/b_rdata when d_vld, else 0.
  - clr coincides with the first product latch, so a stale product from the previous element is never accumulated.
- DRAIN: 1 cycle. The last operand pair reaches the MAC; go to FLUSH.
- FLUSH: 1 cycle. running=1 with zero operands, so the last product is accumulated into the total. Go to WRITE.
- WRITE: 1 cycle.
  - c_wr=1, c_addr = i*N + j (incremental), c_wdata = mac_total, c_err = mac_err.
  - ovf_any |= mac_err.
  - Advance j; on wrap j=N-1→0, advance i.
  - Last element (i=M-1, j=N-1) → DONE; otherwise → ISSUE with k=0.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- ovf_any holds its value until the next accepted start.
- Timing:
  - K+3 cycles per element.
  - Job: start accepted in cycle 0; first ISSUE in cycle 1; done in cycle M*N*(K+3)+1.
- Outputs are in row-major order; each C address is written exactly once.

Optional Feature:
- Macro: MATMUL_MAC_CTRL_PERF_EN.
- Defined:
  - adds output perf_cycles, 32 bits: counts the busy cycles of the last job; cleared on accept, frozen at DONE, reset to 0.
  - adds output perf_ovf_cnt, DIM_W*2 bits: the number of elements with c_err=1 in the job.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package matmul_pkg:
  - state enum typedef mm_state_t.
  - DATA_WIDTH/ACCUM_WIDTH/MAX_DIM defaults.
  - DIM_W/ADDR_W derivation functions.
- Sub-module matmul_addr_gen:
  - i/j/k counters with incremental a/b/c address bases.
  - last_k / last_j / last_elem flags.
  - FSM, operand pipeline and status logic stay in the top module.

Test Plan:
- M=N=K=1, A=3, B=-4, start in cycle 0 → c_wr in cycle 4 with c_addr=0, c_wdata=-12, c_err=0; done in cycle 5.
- M=N=K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → writes 19, 22, 43, 50 at c_addr 0..3 in order; done once.
- Stale-product check: two back-to-back elements with K=1, A=[7,0], B=[5,0] (M=2, N=1) → second write = 0, not 35.
- Overflow: DATA_WIDTH=16, K=2, A row [-32768,-32768], B col [-32768,-32768] → c_err=1 and ovf_any=1; a next job with small values clears ovf_any.
- Config errors: start with cfg_k=0, then start with cfg_m=MAX_DIM+1 → cfg_err pulses each time, busy stays 0, no reads issued.
- Reset mid-job: assert rst during ISSUE of element 1 in a 2x2x2 job → next cycle all outputs 0 and IDLE, no done; a restarted job produces the correct C.
